// File: rtl/fetch_mem_unit.sv
`default_nettype none
// ============================================================================
// Module      : fetch_mem_unit
// Description : Instruction-fetch / data-memory access unit for a multicycle
//               core. It serialises one memory access at a time over a
//               valid/ready request channel and a valid-only response
//               channel. It also owns the architectural pc, old_pc, instr
//               and data_reg registers.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk, rst          : clock, synchronous active-high reset
//   mem_start         : one-cycle access request from the control FSM
//   AdrSrc            : 0 = access address is pc, 1 = Result
//   MemWrite/IRWrite  : select store / fetch kind at mem_start
//   PCWrite           : pc <= Result (any state)
//   Result, WriteData : next-pc / data address, store data
//   mem_req_*         : request channel (valid/ready, addr, we, wdata)
//   mem_rsp_*         : response channel (valid, rdata)
//   pc, old_pc, instr, data_reg : architectural registers
//   opcode, funct3, funct7_5    : instruction fields for control
//   stall, mem_done, misalign_err, bus_err : status
// ============================================================================
module fetch_mem_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          TIMEOUT  = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_start,
  input  logic        AdrSrc,
  input  logic        MemWrite,
  input  logic        IRWrite,
  input  logic        PCWrite,
  input  logic [31:0] Result,
  input  logic [31:0] WriteData,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_addr,
  output logic        mem_we,
  output logic [31:0] mem_wdata,
  input  logic        mem_rsp_valid,
  input  logic [31:0] mem_rdata,
  output logic [31:0] pc,
  output logic [31:0] old_pc,
  output logic [31:0] instr,
  output logic [31:0] data_reg,
  output logic [6:0]  opcode,
  output logic [2:0]  funct3,
  output logic        funct7_5,
  output logic        stall,
  output logic        mem_done,
  output logic        misalign_err,
  output logic        bus_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    KIND_FETCH = 2'd0,
    KIND_LOAD  = 2'd1,
    KIND_STORE = 2'd2
  } kind_t;

  // Counter just wide enough to hold TIMEOUT itself.
  localparam int c_cnt_w = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [c_cnt_w-1:0] c_timeout = c_cnt_w'(TIMEOUT);

  state_t               r_state;
  state_t               w_state_next;
  kind_t                r_kind;
  kind_t                w_start_kind;
  logic [31:0]          r_addr;
  logic [31:0]          r_wdata;
  logic [c_cnt_w-1:0]   r_cnt;
  logic [c_cnt_w-1:0]   w_cnt_inc;
  logic [31:0]          w_start_addr;
  logic [31:0]          r_pc;
  logic [31:0]          r_old_pc;
  logic [31:0]          r_instr;
  logic [31:0]          r_data_reg;
  logic                 r_mem_done;
  logic                 r_misalign;
  logic                 r_bus_err;
  logic                 w_start_ok;
  logic                 w_misalign;
  logic                 w_rsp_take;
  logic                 w_timeout;

  // Address and kind as they would be latched if mem_start is taken now.
  always_comb begin
    w_start_addr = AdrSrc ? Result : r_pc;
    w_start_kind = KIND_LOAD;
    if (!AdrSrc && IRWrite) begin
      w_start_kind = KIND_FETCH;
    end else if (AdrSrc && MemWrite) begin
      w_start_kind = KIND_STORE;
    end
  end

  // r_cnt holds the number of RESP cycles already completed, so the
  // increment equals the count including the current cycle.
  assign w_cnt_inc = r_cnt + c_cnt_w'(1);

  // ---------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // ---------------------------------------------------------------------
  // FSM: next state and per-cycle decode
  // ---------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    w_start_ok   = 1'b0;
    w_misalign   = 1'b0;
    w_rsp_take   = 1'b0;
    w_timeout    = 1'b0;
    case (r_state)
      IDLE: begin
        if (mem_start) begin
          // Only fetches are alignment-checked; a bad fetch never reaches
          // the bus and completes immediately.
          if (w_start_kind == KIND_FETCH && w_start_addr[1:0] != 2'b00) begin
            w_misalign = 1'b1;
          end else begin
            w_start_ok   = 1'b1;
            w_state_next = REQ;
          end
        end
      end
      REQ: begin
        if (mem_req_ready) begin
          w_state_next = RESP;
        end
      end
      RESP: begin
        if (mem_rsp_valid) begin
          w_rsp_take   = 1'b1;
          w_state_next = IDLE;
        end else if (w_cnt_inc == c_timeout) begin
          w_timeout    = 1'b1;
          w_state_next = IDLE;
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // Datapath and status registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_kind     <= KIND_FETCH;
      r_addr     <= 32'h0;
      r_wdata    <= 32'h0;
      r_cnt      <= '0;
      r_pc       <= RESET_PC;
      r_old_pc   <= 32'h0;
      r_instr    <= 32'h0;
      r_data_reg <= 32'h0;
      r_mem_done <= 1'b0;
      r_misalign <= 1'b0;
      r_bus_err  <= 1'b0;
    end else begin
      r_mem_done <= 1'b0;

      // The in-flight access keeps its latched address, so pc may change
      // freely at any time.
      if (PCWrite) begin
        r_pc <= Result;
      end

      if (w_start_ok) begin
        r_addr  <= w_start_addr;
        r_kind  <= w_start_kind;
        r_wdata <= WriteData;
      end

      if (w_misalign) begin
        r_misalign <= 1'b1;
        r_mem_done <= 1'b1;
      end

      if (r_state == REQ) begin
        r_cnt <= '0;
      end else if (r_state == RESP) begin
        r_cnt <= w_cnt_inc;
      end

      if (w_rsp_take) begin
        r_mem_done <= 1'b1;
        case (r_kind)
          // r_pc on the right is the pre-update value even if PCWrite
          // fires in the same cycle.
          KIND_FETCH: begin
            r_instr  <= mem_rdata;
            r_old_pc <= r_pc;
          end
          KIND_LOAD: begin
            r_data_reg <= mem_rdata;
          end
          default: begin
          end
        endcase
      end

      if (w_timeout) begin
        r_bus_err  <= 1'b1;
        r_mem_done <= 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------
  assign mem_req_valid = (r_state == REQ);
  assign mem_addr      = r_addr;
  assign mem_we        = (r_kind == KIND_STORE);
  assign mem_wdata     = r_wdata;
  assign stall         = (r_state != IDLE);

  assign pc            = r_pc;
  assign old_pc        = r_old_pc;
  assign instr         = r_instr;
  assign data_reg      = r_data_reg;
  assign opcode        = r_instr[6:0];
  assign funct3        = r_instr[14:12];
  assign funct7_5      = r_instr[30];

  assign mem_done      = r_mem_done;
  assign misalign_err  = r_misalign;
  assign bus_err       = r_bus_err;

endmodule
`default_nettype wire

// File: tb/tb_fetch_mem_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_mem_unit
// Description : Directed self-checking bench for fetch_mem_unit. It covers
//               fetch, store with backpressure, load with a concurrent pc
//               write, and a fetch that coincides with a pc write. It also
//               covers timeout, misaligned fetch, and reset during a request.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_mem_unit;

  logic        clk;
  logic        rst;
  logic        mem_start;
  logic        AdrSrc;
  logic        MemWrite;
  logic        IRWrite;
  logic        PCWrite;
  logic [31:0] Result;
  logic [31:0] WriteData;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_addr;
  logic        mem_we;
  logic [31:0] mem_wdata;
  logic        mem_rsp_valid;
  logic [31:0] mem_rdata;
  logic [31:0] pc;
  logic [31:0] old_pc;
  logic [31:0] instr;
  logic [31:0] data_reg;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        funct7_5;
  logic        stall;
  logic        mem_done;
  logic        misalign_err;
  logic        bus_err;

  int n_pass  = 0;
  int n_total = 0;

  fetch_mem_unit #(
    .RESET_PC (32'h0000_0000),
    .TIMEOUT  (4)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .mem_start     (mem_start),
    .AdrSrc        (AdrSrc),
    .MemWrite      (MemWrite),
    .IRWrite       (IRWrite),
    .PCWrite       (PCWrite),
    .Result        (Result),
    .WriteData     (WriteData),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_addr      (mem_addr),
    .mem_we        (mem_we),
    .mem_wdata     (mem_wdata),
    .mem_rsp_valid (mem_rsp_valid),
    .mem_rdata     (mem_rdata),
    .pc            (pc),
    .old_pc        (old_pc),
    .instr         (instr),
    .data_reg      (data_reg),
    .opcode        (opcode),
    .funct3        (funct3),
    .funct7_5      (funct7_5),
    .stall         (stall),
    .mem_done      (mem_done),
    .misalign_err  (misalign_err),
    .bus_err       (bus_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock and settle just after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; mem_start = 1'b0; AdrSrc = 1'b0; MemWrite = 1'b0;
    IRWrite = 1'b0; PCWrite = 1'b0; Result = 32'h0; WriteData = 32'h0;
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rdata = 32'h0;
    tick(); tick();
    rst = 1'b0;

    // ---- reset state ----
    chk("rst_pc",        pc,            32'h0);
    chk("rst_old_pc",    old_pc,        32'h0);
    chk("rst_instr",     instr,         32'h0);
    chk("rst_data_reg",  data_reg,      32'h0);
    chk("rst_stall",     stall,         32'h0);
    chk("rst_req_valid", mem_req_valid, 32'h0);
    chk("rst_done",      mem_done,      32'h0);
    chk("rst_misalign",  misalign_err,  32'h0);
    chk("rst_bus_err",   bus_err,       32'h0);

    // ---- fetch at pc=0, ready immediate, response on 2nd RESP cycle ----
    mem_start = 1'b1; AdrSrc = 1'b0; IRWrite = 1'b1; mem_req_ready = 1'b1;
    tick();
    mem_start = 1'b0; IRWrite = 1'b0;
    chk("f_req_valid", mem_req_valid, 32'h1);
    chk("f_addr",      mem_addr,      32'h0);
    chk("f_we",        mem_we,        32'h0);
    chk("f_stall",     stall,         32'h1);
    tick();
    chk("f_resp_valid0", mem_req_valid, 32'h0);
    chk("f_resp_stall",  stall,         32'h1);
    tick();
    mem_rsp_valid = 1'b1; mem_rdata = 32'h0050_0093;
    tick();
    mem_rsp_valid = 1'b0; mem_rdata = 32'h0;
    chk("f_instr",  instr,    32'h0050_0093);
    chk("f_opcode", opcode,   32'h13);
    chk("f_funct3", funct3,   32'h0);
    chk("f_old_pc", old_pc,   32'h0);
    chk("f_done",   mem_done, 32'h1);
    chk("f_idle",   stall,    32'h0);
    tick();
    chk("f_done_pulse", mem_done, 32'h0);

    // ---- store to 0x100 with ready low for 3 cycles ----
    mem_req_ready = 1'b0;
    mem_start = 1'b1; AdrSrc = 1'b1; MemWrite = 1'b1;
    Result = 32'h100; WriteData = 32'hDEAD_BEEF;
    tick();
    mem_start = 1'b0; MemWrite = 1'b0;
    Result = 32'h0000_0777; WriteData = 32'h1111_1111;
    for (int i = 0; i < 4; i++) begin
      chk("s_valid", mem_req_valid, 32'h1);
      chk("s_addr",  mem_addr,      32'h100);
      chk("s_wdata", mem_wdata,     32'hDEAD_BEEF);
      chk("s_we",    mem_we,        32'h1);
      if (i == 3) mem_req_ready = 1'b1;
      tick();
    end
    chk("s_resp_valid0", mem_req_valid, 32'h0);
    mem_rsp_valid = 1'b1; mem_rdata = 32'h1234_5678;
    tick();
    mem_rsp_valid = 1'b0;
    chk("s_done",     mem_done, 32'h1);
    chk("s_data_reg", data_reg, 32'h0);
    chk("s_instr",    instr,    32'h0050_0093);

    // ---- load from 0x40 with PCWrite (Result=0x8) during RESP ----
    mem_start = 1'b1; AdrSrc = 1'b1; Result = 32'h40;
    tick();
    mem_start = 1'b0;
    chk("l_addr", mem_addr, 32'h40);
    chk("l_we",   mem_we,   32'h0);
    tick();
    PCWrite = 1'b1; Result = 32'h8;
    tick();
    PCWrite = 1'b0;
    chk("l_pc",    pc,       32'h8);
    chk("l_addr2", mem_addr, 32'h40);
    chk("l_stall", stall,    32'h1);
    mem_rsp_valid = 1'b1; mem_rdata = 32'hCAFE_F00D;
    tick();
    mem_rsp_valid = 1'b0;
    chk("l_data_reg", data_reg, 32'hCAFE_F00D);
    chk("l_done",     mem_done, 32'h1);
    chk("l_instr",    instr,    32'h0050_0093);

    // ---- fetch at pc=8 whose response coincides with PCWrite ----
    mem_start = 1'b1; AdrSrc = 1'b0; IRWrite = 1'b1;
    tick();
    mem_start = 1'b0; IRWrite = 1'b0;
    chk("c_addr", mem_addr, 32'h8);
    tick();
    mem_rsp_valid = 1'b1; mem_rdata = 32'h4000_5033;
    PCWrite = 1'b1; Result = 32'hC;
    tick();
    mem_rsp_valid = 1'b0; PCWrite = 1'b0;
    chk("c_old_pc",   old_pc,   32'h8);
    chk("c_pc",       pc,       32'hC);
    chk("c_instr",    instr,    32'h4000_5033);
    chk("c_opcode",   opcode,   32'h33);
    chk("c_funct3",   funct3,   32'h5);
    chk("c_funct7_5", funct7_5, 32'h1);

    // ---- timeout: load with no response, TIMEOUT=4 ----
    mem_start = 1'b1; AdrSrc = 1'b1; Result = 32'h200;
    tick();
    mem_start = 1'b0;
    tick();
    for (int k = 0; k < 4; k++) begin
      chk("t_stall",   stall,   32'h1);
      chk("t_bus_err", bus_err, 32'h0);
      tick();
    end
    chk("t_bus_err_set", bus_err,  32'h1);
    chk("t_done",        mem_done, 32'h1);
    chk("t_stall_low",   stall,    32'h0);
    chk("t_data_reg",    data_reg, 32'hCAFE_F00D);
    mem_rsp_valid = 1'b1; mem_rdata = 32'h0000_0BAD;
    tick();
    mem_rsp_valid = 1'b0;
    chk("t_late_data", data_reg, 32'hCAFE_F00D);
    chk("t_late_done", mem_done, 32'h0);
    chk("t_sticky",    bus_err,  32'h1);

    // ---- misaligned fetch at pc=0x2 ----
    PCWrite = 1'b1; Result = 32'h2;
    tick();
    PCWrite = 1'b0;
    mem_start = 1'b1; AdrSrc = 1'b0; IRWrite = 1'b1;
    tick();
    mem_start = 1'b0; IRWrite = 1'b0;
    chk("m_err",   misalign_err,  32'h1);
    chk("m_done",  mem_done,      32'h1);
    chk("m_valid", mem_req_valid, 32'h0);
    chk("m_stall", stall,         32'h0);
    tick();
    chk("m_valid2", mem_req_valid, 32'h0);
    chk("m_sticky", misalign_err,  32'h1);
    chk("m_instr",  instr,         32'h4000_5033);

    // ---- reset asserted while in REQ ----
    PCWrite = 1'b1; Result = 32'h10;
    tick();
    PCWrite = 1'b0;
    mem_req_ready = 1'b0;
    mem_start = 1'b1; AdrSrc = 1'b0; IRWrite = 1'b1;
    tick();
    mem_start = 1'b0; IRWrite = 1'b0;
    chk("r_req_valid", mem_req_valid, 32'h1);
    chk("r_req_addr",  mem_addr,      32'h10);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("r_valid_low", mem_req_valid, 32'h0);
    chk("r_pc",        pc,            32'h0);
    chk("r_stall",     stall,         32'h0);
    chk("r_misalign",  misalign_err,  32'h0);
    chk("r_bus_err",   bus_err,       32'h0);
    chk("r_instr",     instr,         32'h0);
    mem_req_ready = 1'b1;
    mem_rsp_valid = 1'b1; mem_rdata = 32'h0000_1234;
    tick();
    mem_rsp_valid = 1'b0;
    chk("r_late_instr", instr,    32'h0);
    chk("r_late_done",  mem_done, 32'h0);
    chk("r_late_valid", mem_req_valid, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fetch_mem_unit.md
FETCH_MEM_UNIT -- requirements
Module: fetch_mem_unit

Interface
REQ-001 SHALL have parameter RESET_PC, 32'h0000_0000, PC value loaded on reset.
REQ-002 SHALL have parameter TIMEOUT, 255, maximum RESP-state cycles before bus error.
REQ-003 SHALL have port clk  in  1  sole clock, all state updates on rising edge.
REQ-004 SHALL have port rst  in  1  synchronous, active-high reset.
REQ-005 SHALL have port mem_start  in  1  one-cycle request from control FSM to begin a memory access.
REQ-006 SHALL have port AdrSrc  in  1  0 = address from PC (fetch), 1 = address from Result (data access).
REQ-007 SHALL have ports MemWrite, IRWrite, PCWrite  in  1 each  control strobes from main control.
REQ-008 SHALL have ports Result, WriteData  in  32 each  next-PC/data address and store data.
REQ-009 SHALL have ports mem_req_valid  out  1;  mem_req_ready  in  1;  mem_addr  out  32;  mem_we  out  1;  mem_wdata  out  32.
REQ-010 SHALL have ports mem_rsp_valid  in  1;  mem_rdata  in  32  (response/ack, stores included).
REQ-011 SHALL have ports pc, old_pc, instr, data_reg  out  32 each  architectural registers.
REQ-012 SHALL have ports opcode  out  7;  funct3  out  3;  funct7_5  out  1  fields of instr, fed to control.
REQ-013 SHALL have ports stall, mem_done, misalign_err, bus_err  out  1 each  status.

Function
REQ-014 SHALL implement FSM states IDLE, REQ, RESP.
REQ-015 SHALL, in IDLE with mem_start=1, latch address (pc if AdrSrc=0 else Result), kind (fetch if AdrSrc=0 and IRWrite=1; store if AdrSrc=1 and MemWrite=1; else load) and WriteData, then enter REQ next cycle.
REQ-016 SHALL, on mem_start with latched fetch address bits [1:0] != 0, set misalign_err (sticky), pulse mem_done, issue no request, stay IDLE.
REQ-017 SHALL drive mem_req_valid=1 only in REQ, holding mem_addr/mem_we/mem_wdata stable until mem_req_ready=1.
REQ-018 SHALL move REQ->RESP on the cycle mem_req_valid and mem_req_ready are both 1.
REQ-019 SHALL, in RESP on mem_rsp_valid=1: fetch -> instr<=mem_rdata, old_pc<=pc; load -> data_reg<=mem_rdata; store -> no register change; pulse mem_done one cycle; return IDLE.
REQ-020 SHALL ignore mem_rsp_valid in IDLE and REQ.
REQ-021 SHALL count RESP cycles from 0; at count==TIMEOUT without response set bus_err (sticky), pulse mem_done, return IDLE, leave instr/data_reg unchanged.
REQ-022 SHALL drive stall=1 whenever state != IDLE, combinationally.
REQ-023 SHALL ignore mem_start while state != IDLE.
REQ-024 SHALL update pc<=Result on PCWrite=1 in any state; in-flight access uses the latched address.
REQ-025 SHALL, when PCWrite and fetch response coincide, write old_pc with pre-update pc.
REQ-026 SHALL derive opcode=instr[6:0], funct3=instr[14:12], funct7_5=instr[30] combinationally.
REQ-027 SHALL give access latency: mem_req_valid rises 1 cycle after mem_start; mem_done 1 cycle after mem_rsp_valid sample (registered).

Reset
REQ-028 SHALL, on rst=1 at a clock edge, set state IDLE, pc=RESET_PC, old_pc/instr/data_reg=0, counter 0, all status outputs 0, mem_req_valid=0.
REQ-029 SHALL, on reset mid-access, drop the request; late responses after reset are ignored.
REQ-030 SHALL give rst priority over all other inputs.

Verification
REQ-031 SHALL cover fetch: pc=0x0, mem_start, AdrSrc=0, IRWrite=1, ready immediate, rsp rdata=0x00500093 after 2 cycles -> instr=0x00500093, opcode=0x13, old_pc=0x0, one mem_done pulse.
REQ-032 SHALL cover store: AdrSrc=1, MemWrite=1, Result=0x100, WriteData=0xDEADBEEF, ready held low 3 cycles -> addr/wdata/we stable 4 cycles, data_reg unchanged.
REQ-033 SHALL cover load with PCWrite=1 (Result=0x8) during RESP -> pc=0x8 next cycle, mem_addr unchanged, data_reg=rdata.
REQ-034 SHALL cover timeout: TIMEOUT=4, no rsp -> bus_err=1 after 4 RESP cycles, stall=0 next cycle.
REQ-035 SHALL cover misaligned fetch pc=0x2 -> misalign_err=1, mem_req_valid never asserted.
REQ-036 SHALL cover rst asserted in REQ -> mem_req_valid=0 next cycle, pc=RESET_PC, later mem_rsp_valid ignored.
